crc_stream_gen: RTL and testbench

- Streaming CRC generator that sequences the existing combinational `lfsr` core over a byte-wide valid/ready stream.
- Data beats pass through unchanged. The CRC register is seeded at every start of frame and advanced once per accepted beat. At the end of the frame the finalized CRC is appended as extra beats.
- Sits between a frame source and a MAC/serializer; it is the Ethernet FCS inserter when the defaults are used.

---
 rtl/crc_stream_pkg.sv | 19 +
 rtl/lfsr.sv | 62 ++++++
 rtl/crc_stream_gen.sv | 154 +++++++++++++++
 tb/tb_crc_stream_gen.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_stream_pkg.sv
// Shared types and sizing helpers for the streaming CRC generator.
// Pure declarations: no latency, no flow control.
package crc_stream_pkg;

  typedef enum logic {
    DATA   = 1'b0,
    APPEND = 1'b1
  } state_e;

  function automatic int crc_nbytes(input int crcw, input int dw);
    return crcw / dw;
  endfunction

  // The CRC is emitted as whole beats, so its width must split evenly into beats.
  function automatic bit crc_width_ok(input int crcw, input int dw);
    return (dw > 0) && ((crcw % dw) == 0);
  endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational LFSR/CRC core: advances LFSRW-bit state by DW data bits in one step.
// Zero latency, no flow control; the caller decides when to commit state_out.
module lfsr #(
  parameter int               LFSRW        = 32,
  parameter logic [LFSRW-1:0] LFSR_POLY    = 32'h04c11db7,
  parameter int               DW           = 8,
  parameter bit               GALOIS       = 1'b1,
  parameter bit               FEED_FORWARD = 1'b0,
  parameter bit               REVERSE      = 1'b1
) (
  input  logic [LFSRW-1:0] state_in,
  input  logic [DW-1:0]    data_in,
  output logic [LFSRW-1:0] state_out,
  output logic [DW-1:0]    data_out
);

  function automatic logic [LFSRW-1:0] bit_rev(input logic [LFSRW-1:0] v);
    logic [LFSRW-1:0] r;
    for (int i = 0; i < LFSRW; i++) begin
      r[i] = v[LFSRW-1-i];
    end
    return r;
  endfunction

  // LSB-first operation shifts right, so the tap mask is mirrored.
  localparam logic [LFSRW-1:0] TAPS = REVERSE ? bit_rev(LFSR_POLY) : LFSR_POLY;

  logic [LFSRW-1:0] st;
  logic [DW-1:0]    dout;
  logic             din;
  logic             sbit;
  logic             fb;

  always_comb begin
    st   = state_in;
    dout = '0;
    din  = 1'b0;
    sbit = 1'b0;
    fb   = 1'b0;
    for (int i = 0; i < DW; i++) begin
      din = REVERSE ? data_in[i] : data_in[DW-1-i];
      if (GALOIS) begin
        sbit = REVERSE ? st[0] : st[LFSRW-1];
      end else begin
        sbit = ^(st & TAPS);
      end
      fb = FEED_FORWARD ? sbit : (sbit ^ din);
      if (GALOIS) begin
        st = REVERSE ? (st >> 1) : (st << 1);
        if (fb) begin
          st = st ^ TAPS;
        end
      end else begin
        st = REVERSE ? {fb, st[LFSRW-1:1]} : {st[LFSRW-2:0], fb};
      end
      dout[REVERSE ? i : DW-1-i] = FEED_FORWARD ? (sbit ^ din) : fb;
    end
    state_out = st;
    data_out  = dout;
  end

endmodule

// File: rtl/crc_stream_gen.sv
// Streaming CRC inserter: data beats pass through 1 cycle late, finalized CRC appended LSB beat first.
// One output register; input is stalled while it is full and not drained, and throughout CRC append.
module crc_stream_gen
  import crc_stream_pkg::*;
#(
  parameter int              DW      = 8,
  parameter int              CRCW    = 32,
  parameter logic [CRCW-1:0] POLY    = 32'h04c11db7,
  parameter logic [CRCW-1:0] INIT    = 32'hffffffff,
  parameter logic [CRCW-1:0] XOROUT  = 32'hffffffff,
  parameter bit              REVERSE = 1'b1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  output logic [CRCW-1:0] crc_out,
  output logic            crc_valid
);

  localparam int              NBYTES   = crc_nbytes(CRCW, DW);
  localparam int              IW       = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0]   IDX_LAST = IW'(NBYTES - 1);

  if (!crc_width_ok(CRCW, DW)) begin : g_width_chk
    $error("crc_stream_gen: CRCW must be a non-zero multiple of DW");
  end

  state_e          state_q,     state_d;
  logic            sof_q,       sof_d;
  logic [IW-1:0]   idx_q,       idx_d;
  logic [CRCW-1:0] crc_q,       crc_d;
  logic [CRCW-1:0] fcs_q,       fcs_d;
  logic            m_valid_q,   m_valid_d;
  logic [DW-1:0]   m_data_q,    m_data_d;
  logic            m_last_q,    m_last_d;
  logic [CRCW-1:0] crc_out_q,   crc_out_d;
  logic            crc_valid_q, crc_valid_d;

  logic            out_load;
  logic            accept;
  logic [CRCW-1:0] lfsr_state_in;
  logic [CRCW-1:0] lfsr_state_out;
  logic [DW-1:0]   lfsr_data_unused;

  assign lfsr_state_in = sof_q ? INIT : crc_q;

  lfsr #(
    .LFSRW        (CRCW),
    .LFSR_POLY    (POLY),
    .DW           (DW),
    .GALOIS       (1'b1),
    .FEED_FORWARD (1'b0),
    .REVERSE      (REVERSE)
  ) u_lfsr (
    .state_in  (lfsr_state_in),
    .data_in   (s_data),
    .state_out (lfsr_state_out),
    .data_out  (lfsr_data_unused)
  );

  always_comb begin
    state_d     = state_q;
    sof_d       = sof_q;
    idx_d       = idx_q;
    crc_d       = crc_q;
    fcs_d       = fcs_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    crc_out_d   = crc_out_q;
    crc_valid_d = 1'b0;

    out_load = !m_valid_q || m_ready;
    s_ready  = (state_q == DATA) && out_load;
    accept   = s_valid && s_ready;

    // A drained register with nothing new to load goes empty.
    if (out_load) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      DATA: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_last_d  = 1'b0;
          crc_d     = lfsr_state_out;
          sof_d     = s_last;
          if (s_last) begin
            fcs_d       = lfsr_state_out ^ XOROUT;
            crc_out_d   = lfsr_state_out ^ XOROUT;
            crc_valid_d = 1'b1;
            idx_d       = '0;
            state_d     = APPEND;
          end
        end
      end
      APPEND: begin
        if (out_load) begin
          m_valid_d = 1'b1;
          m_data_d  = fcs_q[32'(idx_q) * DW +: DW];
          m_last_d  = (idx_q == IDX_LAST);
          if (idx_q == IDX_LAST) begin
            state_d = DATA;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= DATA;
      sof_q       <= 1'b1;
      idx_q       <= '0;
      crc_q       <= '0;
      fcs_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      crc_out_q   <= '0;
      crc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sof_q       <= sof_d;
      idx_q       <= idx_d;
      crc_q       <= crc_d;
      fcs_q       <= fcs_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      crc_out_q   <= crc_out_d;
      crc_valid_q <= crc_valid_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign crc_out   = crc_out_q;
  assign crc_valid = crc_valid_q;

endmodule

// File: tb/tb_crc_stream_gen.sv
// Bench for crc_stream_gen: byte-level CRC-32 reference model and scoreboard,
// randomized back-pressure and source gaps, plus literal vectors for known frames.
module tb_crc_stream_gen;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic        clk;
  logic        nreset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [31:0] crc_out;
  logic        crc_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cnt  = 0;
  int crc_pulses = 0;
  bit bp = 0;
  int gap_pct = 0;

  beat_t       exp_q[$];
  logic [31:0] crc_q[$];
  logic [7:0]  rec_q[$];
  logic        rec_last[$];
  int          hs_cyc[$];

  bit         in_append = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  crc_stream_gen dut (
    .clk       (clk),
    .nreset    (nreset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .crc_out   (crc_out),
    .crc_valid (crc_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Textbook reflected CRC-32 over a byte list.
  function automatic logic [31:0] crc32_ref(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hffffffff;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  always @(negedge clk) begin
    beat_t b;
    if (nreset) begin
      if (prev_stall) begin
        chk("hold_valid", {63'h0, m_valid}, 64'h1);
        chk("hold_data", {56'h0, m_data}, {56'h0, prev_data});
        chk("hold_last", {63'h0, m_last}, {63'h0, prev_last});
      end
      if (m_valid && m_last) in_append = 0;
      if (crc_valid) begin
        in_append = 1;
        crc_pulses++;
        if (crc_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL crc_valid_unexpected: crc_out=%h with no frame ended", crc_out);
        end else begin
          chk("crc_out", {32'h0, crc_out}, {32'h0, crc_q.pop_front()});
        end
      end
      if (in_append) chk("s_ready_append", {63'h0, s_ready}, 64'h0);
      else           chk("s_ready", {63'h0, s_ready}, {63'h0, (!m_valid || m_ready)});
      if (m_valid && m_ready) begin
        hs_cnt++;
        rec_q.push_back(m_data);
        rec_last.push_back(m_last);
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat_unexpected: m_data=%h m_last=%b with nothing expected", m_data, m_last);
        end else begin
          b = exp_q.pop_front();
          chk("m_data", {56'h0, m_data}, {56'h0, b.d});
          chk("m_last", {63'h0, m_last}, {63'h0, b.l});
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp ? ($urandom_range(1) == 1) : 1'b1;
    end
  end

  task automatic send_frame(input logic [7:0] fr[$]);
    logic        hs;
    int          g;
    logic [31:0] c;
    beat_t       b;
    for (int i = 0; i < fr.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = fr[i];
      s_last  = (i == fr.size() - 1);
      hs = 1'b0; g = 0;
      while (!hs && g < 500) begin
        @(negedge clk);
        hs = s_ready;
        @(posedge clk); #1;
        g++;
      end
      if (!hs) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout: s_ready low for %0d cycles, required a handshake", g);
      end
      b.d = fr[i]; b.l = 1'b0;
      exp_q.push_back(b);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    c = crc32_ref(fr);
    for (int k = 0; k < 4; k++) begin
      b.d = c[8*k +: 8];
      b.l = (k == 3);
      exp_q.push_back(b);
    end
    crc_q.push_back(c);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() > 0 || m_valid) && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
    chk({name, "_crc_drain"}, crc_q.size(), 0);
  endtask

  task automatic clear_rec();
    rec_q.delete(); rec_last.delete(); hs_cyc.delete();
    crc_pulses = 0;
  endtask

  task automatic check_rec(input string name, input logic [7:0] lit[$], input int nlast);
    int lc;
    chk({name, "_len"}, rec_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < rec_q.size(); i++) chk({name, "_byte"}, rec_q[i], lit[i]);
    lc = 0;
    foreach (rec_last[i]) if (rec_last[i]) lc++;
    chk({name, "_last_cnt"}, lc, nlast);
    if (rec_last.size() > 0) chk({name, "_last_end"}, {63'h0, rec_last[rec_last.size()-1]}, 64'h1);
  endtask

  task automatic check_span(input string name, input int span);
    if (hs_cyc.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no output beats, required %0d consecutive", name, span + 1);
    end else begin
      chk(name, hs_cyc[hs_cyc.size()-1] - hs_cyc[0], span);
    end
  endtask

  initial begin
    logic [7:0] f123[$];
    logic [7:0] fz1[$];
    logic [7:0] fz4[$];
    logic [7:0] fr[$];
    logic [7:0] lit1[$];
    logic [7:0] lit2[$];
    logic [7:0] lit6[$];
    int g;

    for (int i = 0; i < 9; i++) f123.push_back(8'(8'h31 + i));
    fz1 = {8'h00};
    fz4 = {8'h00, 8'h00, 8'h00, 8'h00};
    lit1 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    lit2 = {8'h00, 8'h8D, 8'hEF, 8'h02, 8'hD2};
    lit6 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h1C, 8'hDF, 8'h44, 8'h21};

    nreset = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    #1;
    chk("rst_m_valid", {63'h0, m_valid}, 64'h0);
    chk("rst_m_data", {56'h0, m_data}, 64'h0);
    chk("rst_m_last", {63'h0, m_last}, 64'h0);
    chk("rst_crc_out", {32'h0, crc_out}, 64'h0);
    chk("rst_crc_valid", {63'h0, crc_valid}, 64'h0);
    chk("rst_s_ready", {63'h0, s_ready}, 64'h1);
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    @(posedge clk); #1;

    chk("model_123456789", {32'h0, crc32_ref(f123)}, 64'hCBF43926);
    chk("model_00", {32'h0, crc32_ref(fz1)}, 64'hD202EF8D);
    chk("model_00x4", {32'h0, crc32_ref(fz4)}, 64'h2144DF1C);

    // Known frame, no back-pressure.
    clear_rec();
    send_frame(f123);
    drain("t1");
    check_rec("t1", lit1, 1);
    check_span("t1_span", 12);
    chk("t1_crc_pulses", crc_pulses, 1);
    chk("t1_crc_out", {32'h0, crc_out}, 64'hCBF43926);

    // Single-beat frame.
    clear_rec();
    send_frame(fz1);
    drain("t2");
    check_rec("t2", lit2, 1);
    chk("t2_crc_out", {32'h0, crc_out}, 64'hD202EF8D);

    // Back-pressure and source gaps.
    clear_rec();
    bp = 1; gap_pct = 40;
    send_frame(f123);
    drain("t3");
    bp = 0; gap_pct = 0;
    @(posedge clk); #1;
    check_rec("t3", lit1, 1);
    chk("t3_crc_out", {32'h0, crc_out}, 64'hCBF43926);

    // Back-to-back frames without a bubble.
    clear_rec();
    send_frame(f123);
    send_frame(f123);
    drain("t4");
    check_rec("t4", {lit1, lit1}, 2);
    check_span("t4_span", 25);
    chk("t4_crc_pulses", crc_pulses, 2);

    // Reset after two CRC beats have handshaked.
    clear_rec();
    g = hs_cnt;
    send_frame(f123);
    while (hs_cnt < g + 11 && hs_cnt >= g) begin
      @(negedge clk); #1;
      if (cyc > 90000) break;
    end
    @(posedge clk); #2;
    nreset = 1'b0;
    #1;
    chk("t5_rst_m_valid", {63'h0, m_valid}, 64'h0);
    chk("t5_rst_m_data", {56'h0, m_data}, 64'h0);
    chk("t5_rst_m_last", {63'h0, m_last}, 64'h0);
    chk("t5_rst_crc_out", {32'h0, crc_out}, 64'h0);
    chk("t5_rst_crc_valid", {63'h0, crc_valid}, 64'h0);
    exp_q.delete(); crc_q.delete();
    in_append = 0; prev_stall = 0;
    clear_rec();
    repeat (2) @(posedge clk);
    #2 nreset = 1'b1;
    send_frame(f123);
    drain("t5");
    check_rec("t5", lit1, 1);
    chk("t5_crc_out", {32'h0, crc_out}, 64'hCBF43926);

    // All-zero four-beat frame.
    clear_rec();
    send_frame(fz4);
    drain("t6");
    check_rec("t6", lit6, 1);
    chk("t6_crc_out", {32'h0, crc_out}, 64'h2144DF1C);

    // Random frames under random back-pressure.
    bp = 1; gap_pct = 30;
    for (int f = 0; f < 8; f++) begin
      fr.delete();
      for (int i = 0; i < int'($urandom_range(16, 1)); i++) fr.push_back(8'($urandom_range(255)));
      send_frame(fr);
    end
    drain("t7");
    bp = 0; gap_pct = 0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
